// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: ALU/NPC/EXT/WDSel/DMType
// codes, FSM state encoding, instruction classes and opcode constants.
package mc_ctrl_pkg;

    localparam int ALUOP_WIDTH = 5;
    localparam int NPCOP_WIDTH = 3;
    localparam int EXTOP_WIDTH = 6;

    // ALU operation codes
    localparam logic [ALUOP_WIDTH-1:0] ALU_NOP   = 5'b00000;
    localparam logic [ALUOP_WIDTH-1:0] ALU_LUI   = 5'b00001;
    localparam logic [ALUOP_WIDTH-1:0] ALU_AUIPC = 5'b00010;
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = 5'b00011;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = 5'b00100;
    localparam logic [ALUOP_WIDTH-1:0] ALU_BNE   = 5'b00101;
    localparam logic [ALUOP_WIDTH-1:0] ALU_BLT   = 5'b00110;
    localparam logic [ALUOP_WIDTH-1:0] ALU_BGE   = 5'b00111;
    localparam logic [ALUOP_WIDTH-1:0] ALU_BLTU  = 5'b01000;
    localparam logic [ALUOP_WIDTH-1:0] ALU_BGEU  = 5'b01001;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLT   = 5'b01010;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLTU  = 5'b01011;
    localparam logic [ALUOP_WIDTH-1:0] ALU_XOR   = 5'b01100;
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR    = 5'b01101;
    localparam logic [ALUOP_WIDTH-1:0] ALU_AND   = 5'b01110;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLL   = 5'b01111;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SRL   = 5'b10000;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SRA   = 5'b10001;

    // Next-PC select codes
    localparam logic [NPCOP_WIDTH-1:0] NPC_PLUS4  = 3'b000;
    localparam logic [NPCOP_WIDTH-1:0] NPC_BRANCH = 3'b001;
    localparam logic [NPCOP_WIDTH-1:0] NPC_JUMP   = 3'b010;
    localparam logic [NPCOP_WIDTH-1:0] NPC_JALR   = 3'b100;

    // One-hot immediate type codes
    localparam logic [EXTOP_WIDTH-1:0] EXT_SHAMT = 6'b100000;
    localparam logic [EXTOP_WIDTH-1:0] EXT_I     = 6'b010000;
    localparam logic [EXTOP_WIDTH-1:0] EXT_S     = 6'b001000;
    localparam logic [EXTOP_WIDTH-1:0] EXT_B     = 6'b000100;
    localparam logic [EXTOP_WIDTH-1:0] EXT_U     = 6'b000010;
    localparam logic [EXTOP_WIDTH-1:0] EXT_J     = 6'b000001;

    // Register-file write-data select
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    // Data-memory access type
    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    // RV32I base opcodes
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_RALU,
        CLS_IALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILLEGAL
    } inst_class_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: classifies an RV32I instruction from its
// opcode/funct fields and produces ALU operation, immediate type and access type.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0]             op,
    input  logic [6:0]             funct7,
    input  logic [2:0]             funct3,
    output inst_class_e            inst_class,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic [EXTOP_WIDTH-1:0] ext_op,
    output logic [2:0]             dm_type
);

    // Anything not explicitly recognised falls through as ILLEGAL.
    always_comb begin
        inst_class = CLS_ILLEGAL;
        alu_op     = ALU_NOP;
        ext_op     = '0;
        dm_type    = DM_WORD;
        case (op)
            OP_RTYPE: begin
                if (funct7 == 7'b0000000) begin
                    inst_class = CLS_RALU;
                    case (funct3)
                        3'b000:  alu_op = ALU_ADD;
                        3'b001:  alu_op = ALU_SLL;
                        3'b010:  alu_op = ALU_SLT;
                        3'b011:  alu_op = ALU_SLTU;
                        3'b100:  alu_op = ALU_XOR;
                        3'b101:  alu_op = ALU_SRL;
                        3'b110:  alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    inst_class = CLS_RALU;
                    alu_op     = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    inst_class = CLS_RALU;
                    alu_op     = ALU_SRA;
                end
            end
            OP_IALU: begin
                inst_class = CLS_IALU;
                ext_op     = EXT_I;
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: begin
                        ext_op = EXT_SHAMT;
                        alu_op = ALU_SLL;
                        if (funct7 != 7'b0000000) begin
                            inst_class = CLS_ILLEGAL;
                        end
                    end
                    default: begin
                        ext_op = EXT_SHAMT;
                        if (funct7 == 7'b0000000) begin
                            alu_op = ALU_SRL;
                        end else if (funct7 == 7'b0100000) begin
                            alu_op = ALU_SRA;
                        end else begin
                            inst_class = CLS_ILLEGAL;
                        end
                    end
                endcase
            end
            OP_LOAD: begin
                ext_op = EXT_I;
                alu_op = ALU_ADD;
                inst_class = CLS_LOAD;
                case (funct3)
                    3'b000:  dm_type = DM_BYTE;
                    3'b001:  dm_type = DM_HALF;
                    3'b010:  dm_type = DM_WORD;
                    3'b100:  dm_type = DM_BYTE_U;
                    3'b101:  dm_type = DM_HALF_U;
                    default: inst_class = CLS_ILLEGAL;
                endcase
            end
            OP_STORE: begin
                ext_op = EXT_S;
                alu_op = ALU_ADD;
                inst_class = CLS_STORE;
                case (funct3)
                    3'b000:  dm_type = DM_BYTE;
                    3'b001:  dm_type = DM_HALF;
                    3'b010:  dm_type = DM_WORD;
                    default: inst_class = CLS_ILLEGAL;
                endcase
            end
            OP_BRANCH: begin
                ext_op = EXT_B;
                inst_class = CLS_BRANCH;
                case (funct3)
                    3'b000:  alu_op = ALU_SUB;
                    3'b001:  alu_op = ALU_BNE;
                    3'b100:  alu_op = ALU_BLT;
                    3'b101:  alu_op = ALU_BGE;
                    3'b110:  alu_op = ALU_BLTU;
                    3'b111:  alu_op = ALU_BGEU;
                    default: inst_class = CLS_ILLEGAL;
                endcase
            end
            OP_JAL: begin
                inst_class = CLS_JAL;
                ext_op     = EXT_J;
            end
            OP_JALR: begin
                ext_op = EXT_I;
                alu_op = ALU_ADD;
                if (funct3 == 3'b000) begin
                    inst_class = CLS_JALR;
                end
            end
            OP_LUI: begin
                inst_class = CLS_LUI;
                ext_op     = EXT_U;
                alu_op     = ALU_LUI;
            end
            OP_AUIPC: begin
                inst_class = CLS_AUIPC;
                ext_op     = EXT_U;
                alu_op     = ALU_AUIPC;
            end
            default: inst_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// req/ready memory handshake and a retired-instruction counter.
// Optional: define MC_CTRL_TRAP_EN to stop in a TRAP state on illegal instructions
// instead of retiring them as NOPs.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = ALUOP_WIDTH,
    parameter int NPCOP_W = NPCOP_WIDTH,
    parameter int EXTOP_W = EXTOP_WIDTH,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [6:0]         Op,
    input  logic [6:0]         Funct7,
    input  logic [2:0]         Funct3,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [NPCOP_W-1:0] NPCOp,
    output logic [EXTOP_W-1:0] EXTOp,
    output logic [1:0]         WDSel,
    output logic [2:0]         DMType,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   instret,
    output logic               trap
);

    state_e               state_q, state_d;
    inst_class_e          class_q, class_d;
    logic [ALUOP_W-1:0]   alu_op_q, alu_op_d;
    logic [EXTOP_W-1:0]   ext_op_q, ext_op_d;
    logic [2:0]           dm_type_q, dm_type_d;
    logic [CNT_W-1:0]     instret_q, instret_d;
    logic                 retire;

    inst_class_e          dec_class;
    logic [ALUOP_W-1:0]   dec_alu_op;
    logic [EXTOP_W-1:0]   dec_ext_op;
    logic [2:0]           dec_dm_type;

    mc_ctrl_decode u_decode (
        .op         (Op),
        .funct7     (Funct7),
        .funct3     (Funct3),
        .inst_class (dec_class),
        .alu_op     (dec_alu_op),
        .ext_op     (dec_ext_op),
        .dm_type    (dec_dm_type)
    );

    // Next-state, strobes and counter update; everything is forced quiet while rstn is low.
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        alu_op_d  = alu_op_q;
        ext_op_d  = ext_op_q;
        dm_type_d = dm_type_q;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = '0;
        NPCOp     = NPC_PLUS4;
        EXTOp     = '0;
        WDSel     = WD_ALU;
        DMType    = dm_type_q;
        if (rstn) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        NPCOp   = NPC_PLUS4;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    class_d   = dec_class;
                    alu_op_d  = dec_alu_op;
                    ext_op_d  = dec_ext_op;
                    dm_type_d = dec_dm_type;
                    if (dec_class == CLS_ILLEGAL) begin
`ifdef MC_CTRL_TRAP_EN
                        state_d = ST_TRAP;
`else
                        state_d = ST_FETCH;
                        retire  = 1'b1;
`endif
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    ALUOp   = alu_op_q;
                    EXTOp   = ext_op_q;
                    ALUSrcA = (class_q == CLS_AUIPC);
                    ALUSrcB = (class_q inside {CLS_IALU, CLS_LOAD, CLS_STORE,
                                               CLS_LUI, CLS_AUIPC, CLS_JALR});
                    if (class_q == CLS_BRANCH) begin
                        PCWrite = Zero;
                        NPCOp   = NPC_BRANCH;
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end else if (class_q == CLS_LOAD || class_q == CLS_STORE) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (class_q == CLS_STORE);
                    if (mem_ready) begin
                        if (class_q == CLS_STORE) begin
                            state_d = ST_FETCH;
                            retire  = 1'b1;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    if (class_q == CLS_LOAD) begin
                        WDSel = WD_MEM;
                    end else if (class_q == CLS_JAL) begin
                        WDSel   = WD_PC;
                        PCWrite = 1'b1;
                        NPCOp   = NPC_JUMP;
                    end else if (class_q == CLS_JALR) begin
                        WDSel   = WD_PC;
                        PCWrite = 1'b1;
                        NPCOp   = NPC_JALR;
                    end
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
                ST_TRAP: begin
`ifdef MC_CTRL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_FETCH;
`endif
                end
                default: state_d = ST_FETCH;
            endcase
        end
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // State, registered decode results and retire counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_FETCH;
            class_q   <= CLS_NOP;
            alu_op_q  <= '0;
            ext_op_q  <= '0;
            dm_type_q <= DM_WORD;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            alu_op_q  <= alu_op_d;
            ext_op_q  <= ext_op_d;
            dm_type_q <= dm_type_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

`ifdef MC_CTRL_TRAP_EN
    assign trap = (state_q == ST_TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl, built with a 4-bit retire counter so wrap-around
// is reachable. Honours MC_CTRL_TRAP_EN for the illegal-instruction section.
module tb_mc_ctrl;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rstn;
    logic [6:0]          Op;
    logic [6:0]          Funct7;
    logic [2:0]          Funct3;
    logic                Zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                IRWrite;
    logic                PCWrite;
    logic                RegWrite;
    logic                ALUSrcA;
    logic                ALUSrcB;
    logic [4:0]          ALUOp;
    logic [2:0]          NPCOp;
    logic [5:0]          EXTOp;
    logic [1:0]          WDSel;
    logic [2:0]          DMType;
    logic [2:0]          state;
    logic [TB_CNT_W-1:0] instret;
    logic                trap;

    int errors = 0;
    int checks = 0;

    mc_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .Op        (Op),
        .Funct7    (Funct7),
        .Funct3    (Funct3),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .NPCOp     (NPCOp),
        .EXTOp     (EXTOp),
        .WDSel     (WDSel),
        .DMType    (DMType),
        .state     (state),
        .instret   (instret),
        .trap      (trap)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // One comparison point: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive instruction fields and handshake inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic [6:0] op, input logic [6:0] f7,
                                 input logic [2:0] f3, input logic zero, input logic ready);
        Op        = op;
        Funct7    = f7;
        Funct3    = f3;
        Zero      = zero;
        mem_ready = ready;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from FETCH with mem_ready high; check its cycle count.
    task automatic runInstr(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                            input int expCycles, input string tag);
        int n = 0;
        applyStimulus(op, f7, f3, 1'b0, 1'b1);
        do begin
            nextCycle();
            n++;
        end while (state !== 3'd0 && n < 40);
        checkOutput(tag, n, expCycles);
    endtask

    initial begin
        rstn = 1'b0;
        applyStimulus(7'b0010011, 7'b0, 3'b000, 1'b0, 1'b1);
        repeat (2) nextCycle();
        checkOutput("rst_state", state, 3'd0);
        checkOutput("rst_instret", instret, 0);
        checkOutput("rst_trap", trap, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_irwrite", IRWrite, 0);
        checkOutput("rst_pcwrite", PCWrite, 0);
        checkOutput("rst_regwrite", RegWrite, 0);

        // addi x1,x0,5
        rstn = 1'b1;
        applyStimulus(7'b0010011, 7'b0, 3'b000, 1'b0, 1'b1);
        checkOutput("addi_f_req", mem_req, 1);
        checkOutput("addi_f_we", mem_we, 0);
        checkOutput("addi_f_ir", IRWrite, 1);
        checkOutput("addi_f_pc", PCWrite, 1);
        checkOutput("addi_f_npc", NPCOp, 3'b000);
        checkOutput("addi_f_rw", RegWrite, 0);
        nextCycle();
        checkOutput("addi_d_state", state, 3'd1);
        checkOutput("addi_d_ir", IRWrite, 0);
        checkOutput("addi_d_req", mem_req, 0);
        checkOutput("addi_d_rw", RegWrite, 0);
        nextCycle();
        checkOutput("addi_e_state", state, 3'd2);
        checkOutput("addi_e_aluop", ALUOp, 5'b00011);
        checkOutput("addi_e_extop", EXTOp, 6'b010000);
        checkOutput("addi_e_srcb", ALUSrcB, 1);
        checkOutput("addi_e_srca", ALUSrcA, 0);
        checkOutput("addi_e_rw", RegWrite, 0);
        checkOutput("addi_e_ir", IRWrite, 0);
        nextCycle();
        checkOutput("addi_wb_state", state, 3'd4);
        checkOutput("addi_wb_rw", RegWrite, 1);
        checkOutput("addi_wb_wdsel", WDSel, 2'b00);
        checkOutput("addi_wb_pc", PCWrite, 0);
        checkOutput("addi_wb_ir", IRWrite, 0);
        nextCycle();
        checkOutput("addi_done_state", state, 3'd0);
        checkOutput("addi_instret", instret, 1);

        // lw with one FETCH wait and three MEM wait cycles
        applyStimulus(7'b0000011, 7'b0, 3'b010, 1'b0, 1'b0);
        checkOutput("lw_fwait_req", mem_req, 1);
        checkOutput("lw_fwait_ir", IRWrite, 0);
        checkOutput("lw_fwait_pc", PCWrite, 0);
        nextCycle();
        checkOutput("lw_fwait_state", state, 3'd0);
        applyStimulus(7'b0000011, 7'b0, 3'b010, 1'b0, 1'b1);
        checkOutput("lw_f_ir", IRWrite, 1);
        nextCycle();
        nextCycle();
        checkOutput("lw_e_state", state, 3'd2);
        checkOutput("lw_e_aluop", ALUOp, 5'b00011);
        applyStimulus(7'b0000011, 7'b0, 3'b010, 1'b0, 1'b0);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput("lw_mwait_state", state, 3'd3);
            checkOutput("lw_mwait_req", mem_req, 1);
            checkOutput("lw_mwait_we", mem_we, 0);
            nextCycle();
        end
        applyStimulus(7'b0000011, 7'b0, 3'b010, 1'b0, 1'b1);
        checkOutput("lw_m_state", state, 3'd3);
        checkOutput("lw_m_req", mem_req, 1);
        checkOutput("lw_m_dmtype", DMType, 3'b000);
        nextCycle();
        checkOutput("lw_wb_state", state, 3'd4);
        checkOutput("lw_wb_req", mem_req, 0);
        checkOutput("lw_wb_wdsel", WDSel, 2'b01);
        checkOutput("lw_wb_rw", RegWrite, 1);
        nextCycle();
        checkOutput("lw_instret", instret, 2);

        // beq taken, then not taken
        applyStimulus(7'b1100011, 7'b0, 3'b000, 1'b1, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("beq1_e_state", state, 3'd2);
        checkOutput("beq1_e_pc", PCWrite, 1);
        checkOutput("beq1_e_npc", NPCOp, 3'b001);
        checkOutput("beq1_e_rw", RegWrite, 0);
        nextCycle();
        checkOutput("beq1_done_state", state, 3'd0);
        checkOutput("beq1_instret", instret, 3);
        applyStimulus(7'b1100011, 7'b0, 3'b000, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("beq0_e_pc", PCWrite, 0);
        nextCycle();
        checkOutput("beq0_done_state", state, 3'd0);
        checkOutput("beq0_instret", instret, 4);

        // jal
        applyStimulus(7'b1101111, 7'b0, 3'b000, 1'b0, 1'b1);
        repeat (3) nextCycle();
        checkOutput("jal_wb_state", state, 3'd4);
        checkOutput("jal_wb_rw", RegWrite, 1);
        checkOutput("jal_wb_pc", PCWrite, 1);
        checkOutput("jal_wb_wdsel", WDSel, 2'b10);
        checkOutput("jal_wb_npc", NPCOp, 3'b010);
        checkOutput("jal_wb_ir", IRWrite, 0);
        nextCycle();
        checkOutput("jal_instret", instret, 5);

        // Cycle counts for a spread of classes
        runInstr(7'b0110011, 7'b0100000, 3'b000, 4, "sub_cycles");
        runInstr(7'b0010111, 7'b0, 3'b000, 4, "auipc_cycles");
        runInstr(7'b0110111, 7'b0, 3'b000, 4, "lui_cycles");
        runInstr(7'b0100011, 7'b0, 3'b010, 4, "sw_cycles");
        runInstr(7'b1100111, 7'b0, 3'b000, 4, "jalr_cycles");
        runInstr(7'b1100011, 7'b0, 3'b001, 3, "bne_cycles");
        runInstr(7'b0000011, 7'b0, 3'b100, 5, "lbu_cycles");
        checkOutput("mix_instret", instret, 12);

        // srai: shift-amount immediate and arithmetic shift, IR changes after DECODE ignored
        applyStimulus(7'b0010011, 7'b0100000, 3'b101, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        applyStimulus(7'b1101111, 7'b0, 3'b000, 1'b0, 1'b1);
        checkOutput("srai_e_aluop", ALUOp, 5'b10001);
        checkOutput("srai_e_extop", EXTOp, 6'b100000);
        nextCycle();
        checkOutput("srai_wb_wdsel", WDSel, 2'b00);
        checkOutput("srai_wb_pc", PCWrite, 0);
        nextCycle();
        checkOutput("srai_instret", instret, 13);

        // sw aborted by reset during a MEM wait
        applyStimulus(7'b0100011, 7'b0, 3'b010, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        applyStimulus(7'b0100011, 7'b0, 3'b010, 1'b0, 1'b0);
        nextCycle();
        checkOutput("sw_m_state", state, 3'd3);
        checkOutput("sw_m_req", mem_req, 1);
        checkOutput("sw_m_we", mem_we, 1);
        nextCycle();
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("abort_req", mem_req, 0);
        checkOutput("abort_we", mem_we, 0);
        checkOutput("abort_state", state, 3'd0);
        checkOutput("abort_instret", instret, 0);
        checkOutput("abort_rw", RegWrite, 0);
        nextCycle();
        checkOutput("abort_hold_req", mem_req, 0);
        rstn = 1'b1;
        applyStimulus(7'b0010011, 7'b0, 3'b000, 1'b0, 1'b1);
        checkOutput("restart_state", state, 3'd0);
        checkOutput("restart_req", mem_req, 1);
        runInstr(7'b0010011, 7'b0, 3'b000, 4, "restart_addi_cycles");
        checkOutput("restart_instret", instret, 1);

        // Illegal instructions
`ifdef MC_CTRL_TRAP_EN
        applyStimulus(7'b0000000, 7'b0, 3'b000, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("trap_state", state, 3'd5);
        checkOutput("trap_flag", trap, 1);
        checkOutput("trap_req", mem_req, 0);
        checkOutput("trap_ir", IRWrite, 0);
        repeat (3) nextCycle();
        checkOutput("trap_hold_state", state, 3'd5);
        checkOutput("trap_hold_flag", trap, 1);
        checkOutput("trap_instret", instret, 1);
`else
        runInstr(7'b0000000, 7'b0, 3'b000, 2, "illegal_op_cycles");
        checkOutput("illegal_op_instret", instret, 2);
        checkOutput("illegal_trap", trap, 0);
        runInstr(7'b0110011, 7'b0000001, 3'b000, 2, "illegal_f7_cycles");
        runInstr(7'b1100011, 7'b0, 3'b010, 2, "illegal_br_f3_cycles");
        checkOutput("illegal_instret", instret, 4);
`endif

        // Counter wrap with a 4-bit counter
        rstn = 1'b0;
        nextCycle();
        rstn = 1'b1;
        applyStimulus(7'b0010011, 7'b0, 3'b000, 1'b0, 1'b1);
        checkOutput("wrap_start", instret, 0);
        checkOutput("wrap_trap_clear", trap, 0);
        for (int i = 0; i < 15; i++) begin
            runInstr(7'b0010011, 7'b0, 3'b000, 4, "wrap_addi_cycles");
        end
        checkOutput("wrap_15", instret, 15);
        runInstr(7'b0010011, 7'b0, 3'b000, 4, "wrap_addi_cycles");
        checkOutput("wrap_16", instret, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
